// File: rtl/signed_bcd_scan_display.sv
// Signed binary to multiplexed 7-segment display driver.
// Takes a WIDTH-bit two's-complement value, converts its magnitude to BCD with an
// iterative double-dabble engine, then scans the digits out on one shared segment bus.
// Optional feature macro: DISP_SIGN_DIGIT_EN. When defined, the leftmost digit shows
// the sign and leading zeros are blanked.
module signed_bcd_scan_display #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  inputValue,
    output logic              busy,
    output logic              done,
    output logic [DIGITS-1:0] digitSel,
    output logic [6:0]        segOut,
    output logic              signOut
);

    localparam int unsigned BCDW       = 4 * DIGITS;
    localparam int unsigned SHW        = BCDW + WIDTH;
    localparam int unsigned CW         = $clog2(WIDTH + 1);
    localparam int unsigned IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000 + 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Elaboration-time parameter legality checks
    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("WIDTH must be in 2..16");
        end
        if (DIGITS < MIN_DIGITS) begin : g_bad_digits
            $error("DIGITS too small for WIDTH");
        end
        if (SCAN_DIV < 1) begin : g_bad_div
            $error("SCAN_DIV must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [SHW-1:0]   sh, sh_n, adj;
    logic [CW-1:0]    cnt, cnt_n;
    logic             cap_sign, cap_sign_n;
    logic [BCDW-1:0]  disp, disp_n;
    logic             sign_n, busy_n, done_n;
    logic [WIDTH-1:0] mag;
    logic [PW-1:0]    presc, presc_n;
    logic [IW-1:0]    idx, idx_n;

    // Plain numeral decode; anything above 9 shows blank
    function automatic logic [6:0] bcd7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

`ifdef DISP_SIGN_DIGIT_EN
    // Sign in the leftmost digit, leading zeros blanked, digit 0 always a numeral
    function automatic logic [6:0] digit_code(input logic [BCDW-1:0] d, input logic s,
                                              input int unsigned i);
        logic [6:0] code;
        logic       lead;
        code = bcd7(d[4*i +: 4]);
        lead = 1'b1;
        for (int unsigned j = 1; j + 1 < DIGITS; j++) begin
            if (j >= i && d[4*j +: 4] != 4'd0) lead = 1'b0;
        end
        if (i == DIGITS - 1)
            code = s ? SEG_MINUS : SEG_BLANK;
        else if (i != 0 && lead)
            code = SEG_BLANK;
        return code;
    endfunction
`else
    // Every digit shows its magnitude nibble, leading zeros included
    function automatic logic [6:0] digit_code(input logic [BCDW-1:0] d, input int unsigned i);
        return bcd7(d[4*i +: 4]);
    endfunction
`endif

    // Magnitude of the two's-complement input; the most negative value maps to 2^(WIDTH-1)
    assign mag = inputValue[WIDTH-1] ? (~inputValue + WIDTH'(1)) : inputValue;

    // FSM state and conversion/display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            cap_sign <= 1'b0;
            disp     <= '0;
            signOut  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            cnt      <= cnt_n;
            cap_sign <= cap_sign_n;
            disp     <= disp_n;
            signOut  <= sign_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state logic: accept, add-3/shift WIDTH times, then publish to display
    always_comb begin
        state_n    = state;
        sh_n       = sh;
        cnt_n      = cnt;
        cap_sign_n = cap_sign;
        disp_n     = disp;
        sign_n     = signOut;
        busy_n     = busy;
        done_n     = 1'b0;
        adj        = sh;
        case (state)
            IDLE: begin
                if (start) begin
                    sh_n       = {BCDW'(0), mag};
                    cap_sign_n = inputValue[WIDTH-1];
                    cnt_n      = '0;
                    busy_n     = 1'b1;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    if (adj[WIDTH + 4*k +: 4] >= 4'd5)
                        adj[WIDTH + 4*k +: 4] = adj[WIDTH + 4*k +: 4] + 4'd3;
                end
                sh_n  = {adj[SHW-2:0], 1'b0};
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) state_n = DONE;
            end
            DONE: begin
                disp_n  = sh[SHW-1 -: BCDW];
                sign_n  = cap_sign;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Free-running prescaler and scan index
    always_comb begin
        presc_n = presc + PW'(1);
        idx_n   = idx;
        if (presc == PW'(SCAN_DIV - 1)) begin
            presc_n = '0;
            idx_n   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    // Digit enable and segments registered together from next-cycle values, so no skew
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            idx      <= '0;
            digitSel <= ~DIGITS'(1);
            segOut   <= SEG_ZERO;
        end else begin
            presc    <= presc_n;
            idx      <= idx_n;
            digitSel <= ~(DIGITS'(1) << idx_n);
`ifdef DISP_SIGN_DIGIT_EN
            segOut   <= digit_code(disp_n, sign_n, 32'(idx_n));
`else
            segOut   <= digit_code(disp_n, 32'(idx_n));
`endif
        end
    end

endmodule

// File: tb/tb_signed_bcd_scan_display.sv
// Randomized bench for signed_bcd_scan_display (WIDTH=8, DIGITS=4, SCAN_DIV=4).
// A cycle-level behavioural model (arithmetic on the captured value) is compared every
// cycle; literal display patterns pin the model for the directed cases.
module tb_signed_bcd_scan_display;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] inputValue;
    logic         busy, done, signOut;
    logic [D-1:0] digitSel;
    logic [6:0]   segOut;

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    signed_bcd_scan_display #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .start(start), .inputValue(inputValue),
        .busy(busy), .done(done), .digitSel(digitSel), .segOut(segOut), .signOut(signOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;  default: return 7'b1111111;
        endcase
    endfunction

    function automatic int mag_of(input logic [W-1:0] v);
        return v[W-1] ? (256 - int'(v)) : int'(v);
    endfunction

    // Behavioural model state
    int           m_t, m_disp, m_k;
    logic [W-1:0] m_cap;
    logic         m_sign, m_busy, m_done;

    function automatic logic [6:0] exp_seg(input int disp, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p *= 10;
`ifdef DISP_SIGN_DIGIT_EN
        if (i == D - 1) return m_sign ? 7'b0111111 : 7'b1111111;
        if (i > 0 && disp < p) return 7'b1111111;
`endif
        return seg_of((disp / p) % 10);
    endfunction

    // Model: accept when idle, publish WIDTH+1 edges later
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t <= -1; m_disp <= 0; m_sign <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
            m_k <= 0; m_cap <= '0;
        end else begin
            m_k <= m_k + 1;
            if (m_t < 0) begin
                m_done <= 1'b0;
                if (start) begin
                    m_t <= 0; m_cap <= inputValue; m_busy <= 1'b1;
                end
            end else if (m_t == W) begin
                m_disp <= mag_of(m_cap); m_sign <= m_cap[W-1];
                m_done <= 1'b1; m_busy <= 1'b0; m_t <= -1;
            end else begin
                m_t <= m_t + 1; m_done <= 1'b0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (run_chk && !reset) begin
            int i;
            i = (m_k / SD) % D;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("signOut", 32'(signOut), 32'(m_sign));
            chk("digitSel", 32'(digitSel), 32'(4'(~(4'b1 << i))));
            chk("segOut", 32'(segOut), 32'(exp_seg(m_disp, i)));
        end
    end

    task automatic reset_literals();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sign", 32'(signOut), 32'd0);
        chk("rst_digitSel", 32'(digitSel), 32'b1110);
        chk("rst_segOut", 32'(segOut), 32'b1000000);
    endtask

    // One conversion with optional injected start and optional mid-cycle reset
    task automatic conv(input logic [W-1:0] v, input int inj_at, input logic [W-1:0] inj_v,
                        input int rst_at, output int bc, output int dc);
        bc = 0; dc = 0;
        start = 1'b0;
        repeat (12) @(negedge clk);
        start = 1'b1; inputValue = v;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            reset = 1'b0;
            bc += int'(busy); dc += int'(done);
            start = (c == inj_at);
            inputValue = (c == inj_at) ? inj_v : W'($urandom);
            if (c == rst_at) begin
                #2 reset = 1'b1;
                #1 reset_literals();
            end
        end
        start = 1'b0;
    endtask

    // Collect the segment pattern of each digit over one full scan
    task automatic capture(input string name, input logic [27:0] exp);
        logic [27:0] segs;
        int bad;
        bit found;
        segs = '1; bad = 0;
        for (int c = 0; c < SD * D; c++) begin
            @(negedge clk);
            found = 1'b0;
            for (int k = 0; k < D; k++) begin
                if (digitSel == 4'(~(4'b1 << k))) begin
                    segs[7*k +: 7] = segOut; found = 1'b1;
                end
            end
            if (!found) bad++;
        end
        chk({name, "_sel"}, 32'(bad), 32'd0);
        chk({name, "_digits"}, 32'(segs), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int bc, dc;
        logic [W-1:0] picks [4];
        picks[0] = 8'h80; picks[1] = 8'h7F; picks[2] = 8'h00; picks[3] = 8'hFF;
        reset = 1'b1; start = 1'b0; inputValue = '0;
        #1 reset_literals();
        repeat (2) @(negedge clk);
        reset = 1'b0; run_chk = 1'b1;

        // Random stimulus with occasional async resets
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset = 1'b0;
            start = ($urandom % 4 == 0);
            inputValue = ($urandom % 6 == 0) ? picks[$urandom % 4] : W'($urandom);
            if ($urandom % 120 == 0) #2 reset = 1'b1;
        end
        @(negedge clk); reset = 1'b0; start = 1'b0;

        conv(8'd123, 0, 8'd0, 0, bc, dc);
        chk("123_busy_cycles", 32'(bc), 32'd9);
        chk("123_done_cycles", 32'(dc), 32'd1);
        chk("123_sign", 32'(signOut), 32'd0);
`ifdef DISP_SIGN_DIGIT_EN
        capture("123", {7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000});
`else
        capture("123", {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000});
`endif

        conv(8'hF6, 0, 8'd0, 0, bc, dc);
        chk("F6_sign", 32'(signOut), 32'd1);
`ifdef DISP_SIGN_DIGIT_EN
        capture("F6", {7'b0111111, 7'b1111111, 7'b1111001, 7'b1000000});
`else
        capture("F6", {7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000});
`endif

        conv(8'h80, 0, 8'd0, 0, bc, dc);
        chk("80_sign", 32'(signOut), 32'd1);
`ifdef DISP_SIGN_DIGIT_EN
        capture("80", {7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000});
`else
        capture("80", {7'b1000000, 7'b1111001, 7'b0100100, 7'b0000000});
`endif

        conv(8'd45, 3, 8'd99, 0, bc, dc);
        chk("45_busy_cycles", 32'(bc), 32'd9);
        chk("45_done_cycles", 32'(dc), 32'd1);
`ifdef DISP_SIGN_DIGIT_EN
        capture("45", {7'b1111111, 7'b1111111, 7'b0011001, 7'b0010010});
`else
        capture("45", {7'b1000000, 7'b1000000, 7'b0011001, 7'b0010010});
`endif

        conv(8'd77, 0, 8'd0, 4, bc, dc);
        chk("77_busy_cycles", 32'(bc), 32'd4);
        chk("77_done_cycles", 32'(dc), 32'd0);
`ifdef DISP_SIGN_DIGIT_EN
        capture("77rst", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
`else
        capture("77rst", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
`endif

        conv(8'd7, 0, 8'd0, 0, bc, dc);
        chk("7_done_cycles", 32'(dc), 32'd1);
`ifdef DISP_SIGN_DIGIT_EN
        capture("7", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
`else
        capture("7", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000});
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_bcd_scan_display.md
Name: signed_bcd_scan_display

Overview:
- Parametrised signed-value display driver for multiplexed common-anode 7-segment banks. Generalises the two-digit combinational display path to WIDTH-bit two's-complement inputs and DIGITS digits.
- Converts magnitude to BCD with an iterative double-dabble engine and drives one shared segment bus with time-multiplexed digit enables.
- Sits between the ALU result register and the board display pins.

Parameters:
- WIDTH, 8, input value width in bits, two's complement, 2..16.
- DIGITS, 4, number of physical digits. Must satisfy DIGITS >= ceil(WIDTH*0.30103)+1, enforced by elaboration-time check.
- SCAN_DIV, 50000, clock cycles per digit dwell, >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of inputValue. Sampled only in IDLE.
- inputValue  input  WIDTH  signed two's-complement value to display.
- busy  output  1  registered; high while conversion in progress.
- done  output  1  registered; one-cycle pulse when new value is latched to the display.
- digitSel  output  DIGITS  active-low one-hot digit enable. Bit 0 is the rightmost (least significant) digit.
- segOut  output  7  active-low segments {g,f,e,d,c,b,a} for the selected digit.
- signOut  output  1  high when the displayed value is negative.

Behaviour:
- Reset (async, immediate), all registers cleared:
  - busy=0, done=0, state=IDLE, displayed digits all 0, sign=0.
  - Scan index=0, prescaler=0, so digitSel=~1 and segOut=7'b1000000 ('0').
- Magnitude conversion:
  - If inputValue[WIDTH-1]=1, mag = (~inputValue)+1 as WIDTH-bit unsigned, else mag = inputValue.
  - -2^(WIDTH-1) yields 2^(WIDTH-1); for example, 8'h80 gives 128.
- FSM states IDLE, SHIFT, DONE.
  - IDLE: at an edge with start=1, load shift register {4*DIGITS zeros, mag}, capture sign, set count=0, go to SHIFT, busy<=1.
  - SHIFT: each edge, add 3 to every BCD nibble >=5, then shift the whole register left by 1; count++. The edge performing shift number WIDTH goes to DONE. Exactly WIDTH cycles are spent in SHIFT.
  - DONE: one edge copies the BCD nibbles to the display register and the captured sign to signOut, sets done<=1 and busy<=0, then returns to IDLE.
- Latency: start sampled at edge 0, busy high after edges 0..WIDTH, done high for exactly the cycle after edge WIDTH+1.
- start in SHIFT or DONE is ignored, with no queuing. start held high across DONE starts a new conversion at the first IDLE edge.
- inputValue is sampled only at the accepting edge; later changes have no effect on the running conversion.
- Display register and signOut keep the previous value for the whole conversion and change only at DONE.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the scan index advances and wraps from DIGITS-1 to 0.
  - digitSel bit[index]=0, all others 1.
  - segOut is the registered decode of the display nibble at the current index, updated on the same edge as digitSel, so there is no skew.
- Segment codes (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, minus=0111111
  - Nibbles >9 are impossible after conversion; they decode to blank.
- Reset asserted mid-conversion aborts immediately with no done pulse and returns to reset values.

Optional Feature:
- Macro DISP_SIGN_DIGIT_EN.
- Defined:
  - Leftmost digit (index DIGITS-1) is reserved for the sign: minus when negative, blank otherwise.
  - Leading zeros among digits DIGITS-2..1 are blanked. Digit 0 always shows a numeral.
  - signOut still driven.
  - At reset, leftmost digit is blank and the others are blank except digit 0 ('0').
- Undefined: all digits show magnitude nibbles including leading zeros; sign appears on signOut only.

Test Plan (WIDTH=8, DIGITS=4, SCAN_DIV=4, macro undefined unless stated):
- Assert reset mid-run -> busy=0, done=0, signOut=0, digitSel=4'b1110, segOut=7'b1000000 immediately, without waiting for a clock edge.
- inputValue=8'd123, start 1 cycle -> busy high 9 cycles, done pulse 1 cycle. Digits 0..3 = 3,2,1,0; signOut=0. Over 16 cycles digitSel sequence is 1110,1101,1011,0111, segOut 0110000, 0100100, 1111001, 1000000.
- inputValue=8'hF6 (-10) -> digits 0,1,0,0; signOut=1. Same value with DISP_SIGN_DIGIT_EN -> digit3=0111111, digit2=1111111, digit1=1111001, digit0=1000000.
- inputValue=8'h80 -> digits 8,2,1,0, signOut=1.
- Start 8'd45, then pulse start with 8'd99 on the 3rd busy cycle -> second start ignored. Display shows the old value until done, then 5,4,0,0; no second done.
- Start 8'd77, assert reset at 4th busy cycle -> no done. Display returns to all-0, and a subsequent start with 8'd7 completes normally with digits 7,0,0,0.
